// File: rtl/q2_outport_pkg.sv
// q2_outport shared definitions: bus addresses, TX/sequencer states,
// and the nibble-to-ASCII helper used by the character sequencer.
package q2_outport_pkg;

  localparam logic [11:0] Q2_OUT_ADDR  = 12'hFFF;
  localparam logic [11:0] Q2_STAT_ADDR = 12'hFFE;
  localparam logic [7:0]  Q2_LF        = 8'h0A;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_st_e;

  typedef enum logic {
    SQ_IDLE,
    SQ_RUN
  } sq_st_e;

  function automatic logic [7:0] q2_hex2ascii(
    input logic [3:0] n
  );
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] q2_char(
    input logic [11:0] w,
    input logic [1:0]  ci
  );
    logic [7:0] c;
    case (ci)
      2'd0:    c = q2_hex2ascii(w[11:8]);
      2'd1:    c = q2_hex2ascii(w[7:4]);
      2'd2:    c = q2_hex2ascii(w[3:0]);
      default: c = Q2_LF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/q2_uart_tx.sv
// 8N1 bit engine: START/DATA/STOP with a CLK_DIV cycle bit counter.
// ready is high in IDLE and in the last STOP cycle (chaining without gap).
module q2_uart_tx
  import q2_outport_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  tx_st_e        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitn, bit_n;
  logic [7:0]    sh, sh_n;
  logic          last;

  assign last = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= TX_IDLE;
      cnt  <= '0;
      bitn <= '0;
      sh   <= '0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      bitn <= bit_n;
      sh   <= sh_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt + 1'b1;
    bit_n = bitn;
    sh_n  = sh;
    ready = 1'b0;
    tx    = 1'b1;
    unique case (st)
      TX_IDLE: begin
        ready = 1'b1;
        cnt_n = '0;
        if (valid) begin
          st_n = TX_START;
          sh_n = data;
        end
      end
      TX_START: begin
        tx = 1'b0;
        if (last) begin
          st_n  = TX_DATA;
          cnt_n = '0;
          bit_n = '0;
        end
      end
      TX_DATA: begin
        tx = sh[0];
        if (last) begin
          cnt_n = '0;
          sh_n  = {1'b0, sh[7:1]};
          bit_n = bitn + 3'd1;
          if (bitn == 3'd7) st_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (last) begin
          ready = 1'b1;
          cnt_n = '0;
          if (valid) begin
            st_n = TX_START;
            sh_n = data;
          end else begin
            st_n = TX_IDLE;
          end
        end
      end
      default: st_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/q2_outport.sv
// q2 console port: captures writes to OUT_ADDR, sends "HHH\n" over 8N1.
// Q2_OUTPORT_STATUS_EN adds a status read at OUT_ADDR-1 that clears ovf.
module q2_outport
  import q2_outport_pkg::*;
#(
  parameter int          CLK_DIV  = 434,
  parameter int          DEPTH    = 4,
  parameter logic [11:0] OUT_ADDR = Q2_OUT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  inout  wire  [11:0] dbus,
  input  logic        wrm,
  input  logic        rdm,
  output logic        tx,
  output logic        busy,
  output logic        ovf
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, empty;
  logic          wrm_q, wr_ev;
  logic          push, pop, ovf_set, rd_clr;

  sq_st_e      sq, sq_n;
  logic [1:0]  ci, ci_n;
  logic [11:0] hold, hold_n;
  logic        u_valid, u_ready;
  logic [7:0]  u_data;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_ev   = wrm & ~wrm_q & (abus == OUT_ADDR);
  assign pop     = (sq == SQ_IDLE) & ~empty;
  assign push    = wr_ev & (~full | pop);
  assign ovf_set = wr_ev & full & ~pop;
  assign busy    = ~empty | (sq != SQ_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dbus;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrm_q <= 1'b0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      wrm_q <= wrm;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // a same-cycle overflow beats the read-clear
      if (ovf_set)     ovf <= 1'b1;
      else if (rd_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq   <= SQ_IDLE;
      ci   <= '0;
      hold <= '0;
    end else begin
      sq   <= sq_n;
      ci   <= ci_n;
      hold <= hold_n;
    end
  end

  always_comb begin
    sq_n    = sq;
    ci_n    = ci;
    hold_n  = hold;
    u_valid = 1'b0;
    u_data  = q2_char(hold, ci + 2'd1);
    unique case (sq)
      SQ_IDLE: begin
        if (!empty) begin
          sq_n    = SQ_RUN;
          ci_n    = '0;
          hold_n  = mem[rptr];
          u_valid = 1'b1;
          u_data  = q2_char(mem[rptr], 2'd0);
        end
      end
      SQ_RUN: begin
        if (u_ready) begin
          if (ci == 2'd3) begin
            sq_n = SQ_IDLE;
          end else begin
            ci_n    = ci + 2'd1;
            u_valid = 1'b1;
          end
        end
      end
      default: sq_n = SQ_IDLE;
    endcase
  end

  q2_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (u_data),
    .valid (u_valid),
    .ready (u_ready),
    .tx    (tx)
  );

`ifdef Q2_OUTPORT_STATUS_EN
  logic rdm_q, stat_sel;

  assign stat_sel = rdm & (abus == OUT_ADDR - 12'd1);
  assign rd_clr   = stat_sel & ~rdm_q;
  assign dbus     = stat_sel ? {8'h00, ovf, full, ~empty, busy}
                             : 12'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdm_q <= 1'b0;
    else      rdm_q <= rdm;
  end
`else
  logic unused_rdm;

  assign unused_rdm = rdm;
  assign rd_clr     = 1'b0;
  assign dbus       = 12'bz;
`endif

endmodule

// File: tb/tb_q2_outport.sv
// Directed bench for q2_outport (CLK_DIV=4, DEPTH=4) with a UART decoder.
// Status-read scenario runs only when Q2_OUTPORT_STATUS_EN is defined.
module tb_q2_outport;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] abus;
  wire  [11:0] dbus;
  logic [11:0] tb_dat;
  logic        tb_en;
  logic        wrm;
  logic        rdm;
  logic        tx;
  logic        busy;
  logic        ovf;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dbus = tb_en ? tb_dat : 12'bz;

  q2_outport #(
    .CLK_DIV  (CLK_DIV),
    .DEPTH    (DEPTH),
    .OUT_ADDR (12'hFFF)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .abus (abus),
    .dbus (dbus),
    .wrm  (wrm),
    .rdm  (rdm),
    .tx   (tx),
    .busy (busy),
    .ovf  (ovf)
  );

  task automatic do_reset;
    rst   = 1'b0;
    wrm   = 1'b0;
    rdm   = 1'b0;
    tb_en = 1'b0;
    abus  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [11:0] d);
    @(negedge clk);
    abus   = a;
    tb_dat = d;
    tb_en  = 1'b1;
    wrm    = 1'b1;
    @(negedge clk);
    wrm   = 1'b0;
    tb_en = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output bit ok,
                         output int t0);
    int n;
    ok = 1'b1;
    b  = '0;
    t0 = 0;
    n  = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    t0 = cyc;
    repeat (CLK_DIV / 2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CLK_DIV) @(negedge clk);
      b[i] = tx;
    end
    repeat (CLK_DIV) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic rx_word(output logic [31:0] w, output bit ok,
                         output int t0);
    logic [7:0] b;
    bit         k;
    int         t;
    ok = 1'b1;
    w  = '0;
    t0 = 0;
    for (int i = 0; i < 4; i++) begin
      rx_byte(b, k, t);
      if (i == 0) t0 = t;
      if (!k) ok = 1'b0;
      w = {w[23:0], b};
      if (!k) return;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    wrm   = 1'b0;
    rdm   = 1'b0;
    tb_en = 1'b0;
    abus  = '0;
    tb_dat = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b want 1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b want 0", ovf);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [31:0] w;
    bit          ok;
    int          t0, n;
    do_reset;
    bus_write(12'hFFF, 12'h1A3);
    rx_word(w, ok, t0);
    checks++;
    if (!ok || w !== 32'h3141330A) begin
      errors++;
      $display("FAIL single_word: got %h ok=%0d want 3141330a", w, ok);
    end
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc - t0 != 160) begin
      errors++;
      $display("FAIL single_busy_len: got %0d want 160", cyc - t0);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL single_ovf: got %b want 0", ovf);
    end
  endtask

  task automatic test_addr_filter;
    bit saw_low, saw_busy;
    do_reset;
    bus_write(12'hFFE, 12'h555);
    bus_write(12'h000, 12'h555);
    saw_low  = 1'b0;
    saw_busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1)   saw_low  = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    checks++;
    if (saw_low) begin
      errors++;
      $display("FAIL filter_tx: got activity want idle");
    end
    checks++;
    if (saw_busy) begin
      errors++;
      $display("FAIL filter_busy: got 1 want 0");
    end
  endtask

  task automatic test_held;
    logic [31:0] w;
    bit          ok, extra;
    int          t0;
    do_reset;
    fork
      begin
        @(negedge clk);
        abus   = 12'hFFF;
        tb_dat = 12'h0F0;
        tb_en  = 1'b1;
        wrm    = 1'b1;
        repeat (10) @(negedge clk);
        wrm   = 1'b0;
        tb_en = 1'b0;
      end
      rx_word(w, ok, t0);
    join
    checks++;
    if (!ok || w !== 32'h3046300A) begin
      errors++;
      $display("FAIL held_word: got %h ok=%0d want 3046300a", w, ok);
    end
    repeat (4) @(negedge clk);
    extra = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL held_once: got second word want one");
    end
  endtask

  task automatic test_overflow;
    logic [31:0] w, e;
    bit          ok, extra;
    int          t0;
    do_reset;
    fork
      for (int i = 1; i <= 6; i++) bus_write(12'hFFF, 12'(i));
      for (int j = 1; j <= 5; j++) begin
        e = 32'h3030300A | ((32'h30 + 32'(j)) << 8);
        rx_word(w, ok, t0);
        checks++;
        if (!ok || w !== e) begin
          errors++;
          $display("FAIL ovf_word%0d: got %h ok=%0d want %h",
                   j, w, ok, e);
        end
      end
    join
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %b want 1", ovf);
    end
    repeat (4) @(negedge clk);
    extra = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL ovf_drop: got sixth word want dropped");
    end
  endtask

  task automatic test_push_pop_full;
    logic [11:0] pw [6];
    logic [31:0] pe [6];
    logic [31:0] w;
    bit          ok;
    int          t0;
    pw = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h0F9};
    pe = '{32'h3132330A, 32'h3435360A, 32'h3738390A,
           32'h4142430A, 32'h4445460A, 32'h3046390A};
    do_reset;
    fork
      begin
        for (int i = 0; i < 5; i++) bus_write(12'hFFF, pw[i]);
        repeat (152) @(negedge clk);
        bus_write(12'hFFF, pw[5]);
      end
      for (int j = 0; j < 6; j++) begin
        rx_word(w, ok, t0);
        checks++;
        if (!ok || w !== pe[j]) begin
          errors++;
          $display("FAIL pushpop_word%0d: got %h ok=%0d want %h",
                   j, w, ok, pe[j]);
        end
      end
    join
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_ovf: got %b want 0", ovf);
    end
  endtask

  task automatic test_reset_mid;
    bit extra;
    do_reset;
    bus_write(12'hFFF, 12'h1A3);
    bus_write(12'hFFF, 12'h2B4);
    repeat (7) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_data_bit: got %b want 0", tx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_tx: got %b want 1", tx);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_busy: got %b want 0", busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    extra = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) extra = 1'b1;
    end
    checks++;
    if (extra) begin
      errors++;
      $display("FAIL mid_fifo_flush: got activity want idle");
    end
  endtask

`ifdef Q2_OUTPORT_STATUS_EN
  task automatic test_status;
    do_reset;
    for (int i = 1; i <= 6; i++) bus_write(12'hFFF, 12'(i));
    repeat (170) @(negedge clk);
    abus = 12'hFFE;
    rdm  = 1'b1;
    #1;
    checks++;
    if (dbus !== 12'h00B) begin
      errors++;
      $display("FAIL status_read1: got %h want 00b", dbus);
    end
    @(negedge clk);
    rdm = 1'b0;
    @(negedge clk);
    rdm = 1'b1;
    #1;
    checks++;
    if (dbus !== 12'h003) begin
      errors++;
      $display("FAIL status_read2: got %h want 003", dbus);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL status_clr: got %b want 0", ovf);
    end
    @(negedge clk);
    rdm  = 1'b0;
    abus = '0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_addr_filter;
    test_held;
    test_overflow;
    test_push_pop_full;
    test_reset_mid;
`ifdef Q2_OUTPORT_STATUS_EN
    test_status;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
